// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// router_pkg : shared mesh-router constants and helpers
// Rev 1.0
// ============================================================================
package router_pkg;

  localparam int FLIT_W    = 64;
  localparam int NUM_VC    = 2;

  localparam int PORT_N    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_S    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_L    = 4;
  localparam int NUM_PORTS = 5;

  // Pointer width that stays legal for a single-input configuration.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin arbiter, search starts at ptr
// Rev 1.0
// ============================================================================
module rr_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int PTR_W  = ptr_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_IN-1:0] grant,
  output logic [PTR_W-1:0]  winner
);

  logic found;

  // The req loop is only entered when enabled, so X on req cannot leak out.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    if (enable) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!found && req[(int'(ptr) + k) % NUM_IN]) begin
          grant[(int'(ptr) + k) % NUM_IN] = 1'b1;
          winner = PTR_W'((int'(ptr) + k) % NUM_IN);
          found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_output_arbiter.sv
`default_nettype none
// ============================================================================
// router_output_arbiter : per-output-port two-VC round-robin scheduler
// Rev 1.0
// ============================================================================
module router_output_arbiter #(
  parameter int NUM_IN = router_pkg::NUM_PORTS,
  parameter int FLIT_W = router_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     polarity,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN*FLIT_W-1:0] data_in,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic                     out_send,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_polarity
);

  localparam int NUM_VC = router_pkg::NUM_VC;
  localparam int PTR_W  = router_pkg::ptr_width(NUM_IN);

  logic [NUM_VC-1:0][FLIT_W-1:0] slot_data;
  logic [NUM_VC-1:0]             slot_valid;
  logic [NUM_VC-1:0][PTR_W-1:0]  rr_ptr;

  logic              consume;
  logic              slot_free;
  logic              any_grant;
  logic [PTR_W-1:0]  winner;
  logic [FLIT_W-1:0] win_data;

  assign out_polarity = polarity;
  assign out_send     = slot_valid[polarity];
  assign out_data     = slot_valid[polarity] ? slot_data[polarity] : '0;
  assign consume      = out_send && out_ready;
  assign slot_free    = !slot_valid[polarity] || consume;
  assign any_grant    = |grant;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_ptr[polarity]),
    .enable (reset_n && slot_free),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        win_data = data_in[i*FLIT_W +: FLIT_W];
      end
    end
  end

  // Only the active VC's slot and pointer move; the other VC is frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_data  <= '0;
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else if (any_grant) begin
      slot_data[polarity]  <= win_data;
      slot_valid[polarity] <= 1'b1;
      rr_ptr[polarity]     <= (winner == PTR_W'(NUM_IN - 1)) ? '0 : winner + PTR_W'(1);
    end else if (consume) begin
      slot_valid[polarity] <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
`default_nettype none
// ============================================================================
// tb_router_output_arbiter : scoreboard bench with a queue-based VC model
// Rev 1.0
// ============================================================================
module tb_router_output_arbiter;
  import router_pkg::*;

  localparam int N = NUM_PORTS;
  localparam int W = FLIT_W;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           polarity = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   grant;
  logic           out_send;
  logic [W-1:0]   out_data;
  logic           out_polarity;

  always #5 clk = ~clk;

  router_output_arbiter #(.NUM_IN(N), .FLIT_W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .polarity     (polarity),
    .req          (req),
    .data_in      (data_in),
    .out_ready    (out_ready),
    .grant        (grant),
    .out_send     (out_send),
    .out_data     (out_data),
    .out_polarity (out_polarity)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: flits expected to leave each VC, in order.
  logic [W-1:0] expq [2][$];
  // Reference model: per-VC occupancy and "whose turn is next".
  bit           m_valid [2];
  int           m_next  [2];
  logic [W-1:0] dv [N];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void rand_dv();
    for (int i = 0; i < N; i++) dv[i] = {$urandom, $urandom};
  endfunction

  // Monitor: compares the presented flit with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset out_send", 64'(out_send), 64'd0);
        check("reset out_data", out_data, 64'd0);
      end else begin
        check("out_polarity", 64'(out_polarity), 64'(polarity));
        check("out_send", 64'(out_send), 64'(expq[polarity].size() != 0));
        if (out_send && expq[polarity].size() != 0) begin
          check("out_data", out_data, expq[polarity][0]);
          if (out_ready) void'(expq[polarity].pop_front());
        end else if (!out_send) begin
          check("idle out_data", out_data, 64'd0);
        end
      end
    end
  end

  // One arbitration cycle: drive, then check grant against the model and
  // push the winning flit into the scoreboard.
  task automatic cycle(input logic pol, input logic [N-1:0] r, input logic rdy,
                       output logic [N-1:0] g);
    int p;
    int win;
    bit free;
    logic [N-1:0] exp_g;
    @(posedge clk);
    #1;
    polarity  = pol;
    req       = r;
    out_ready = rdy;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = dv[i];
    @(negedge clk);
    #1;
    g     = grant;
    p     = int'(pol);
    free  = !m_valid[p] || rdy;
    win   = -1;
    exp_g = '0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && r[(m_next[p] + k) % N]) win = (m_next[p] + k) % N;
      end
    end
    if (win >= 0) exp_g[win] = 1'b1;
    check("grant", 64'(g), 64'(exp_g));
    if (win >= 0) begin
      expq[p].push_back(dv[win]);
      m_valid[p] = 1'b1;
      m_next[p]  = (win + 1) % N;
    end else if (m_valid[p] && rdy) begin
      m_valid[p] = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    polarity  = 1'b0;
    req       = '1;
    out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async reset grant", 64'(grant), 64'd0);
    check("async reset out_send", 64'(out_send), 64'd0);
    check("async reset out_data", out_data, 64'd0);
    expq[0].delete();
    expq[1].delete();
    m_valid = '{1'b0, 1'b0};
    m_next  = '{0, 0};
    req = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  logic [N-1:0] g;

  initial begin
    m_valid = '{1'b0, 1'b0};
    m_next  = '{0, 0};
    rand_dv();

    // Power-on reset with unknown requests.
    req = 'x;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("X req under reset grant", 64'(grant), 64'd0);
    check("power-on out_send", 64'(out_send), 64'd0);
    @(posedge clk);
    #1;
    req = '0;
    reset_n = 1'b1;

    // Asynchronous reset mid-cycle, then first VC1 grant.
    pulse_reset();
    cycle(1'b0, 5'b11111, 1'b1, g);
    check("first grant after reset", 64'(g), 64'b00001);

    // Single flit on VC1 with toggling polarity.
    rand_dv();
    dv[2] = 64'hDEAD_BEEF_0000_0001;
    cycle(1'b0, 5'b00100, 1'b1, g);
    check("single flit grant", 64'(g), 64'b00100);
    rand_dv();
    cycle(1'b1, 5'b00000, 1'b1, g);
    cycle(1'b0, 5'b00000, 1'b1, g);
    check("single flit send", 64'(out_send), 64'd1);
    check("single flit data", out_data, 64'hDEAD_BEEF_0000_0001);

    // Round-robin order with pointer wrap.
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      rand_dv();
      cycle(1'b0, 5'b11111, 1'b1, g);
      check("round robin order", 64'(g), 64'(1 << (k % N)));
    end

    // Backpressure: slot 0 holds 5 while downstream stalls.
    rand_dv();
    dv[1] = 64'h5;
    cycle(1'b0, 5'b00010, 1'b1, g);
    dv[1] = 64'h6;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 5'b00010, 1'b0, g);
      check("backpressure grant", 64'(g), 64'd0);
      check("backpressure data", out_data, 64'h5);
    end
    cycle(1'b0, 5'b00010, 1'b1, g);
    check("drain and refill grant", 64'(g), 64'b00010);

    // VC independence: VC1 stalled, VC2 streams.
    for (int k = 0; k < 4; k++) begin
      rand_dv();
      cycle(1'b0, 5'b11111, 1'b0, g);
      check("blocked VC1 grant", 64'(g), 64'd0);
      check("blocked VC1 data", out_data, 64'h6);
      dv[3] = 64'hA;
      cycle(1'b1, 5'b01000, 1'b1, g);
      check("VC2 grant", 64'(g), 64'b01000);
      if (k > 0) check("VC2 streaming send", 64'(out_send), 64'd1);
    end
    rand_dv();
    cycle(1'b0, 5'b11111, 1'b1, g);
    check("VC1 pointer preserved", 64'(g), 64'b00100);

    // Zero-valued flit from input 0.
    rand_dv();
    dv[0] = 64'h0;
    cycle(1'b0, 5'b00001, 1'b1, g);
    check("zero flit grant", 64'(g), 64'b00001);
    rand_dv();
    cycle(1'b1, 5'b00000, 1'b1, g);
    cycle(1'b0, 5'b00000, 1'b0, g);
    check("zero flit send", 64'(out_send), 64'd1);
    check("zero flit data", out_data, 64'd0);

    // Randomized traffic on both VCs.
    for (int k = 0; k < 600; k++) begin
      rand_dv();
      cycle(1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 9) < 7), g);
      if (k == 300) pulse_reset();
    end

    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
